mlp_in_packer: RTL
==================

// Module: mlp_in_packer
// PURPOSE
//  Serial-to-parallel front end for the MLP datapath (mlp_c1 family). Accepts one
//  signed fixed-point feature per beat on a valid/ready stream and packs IN_DIM
//  features into the flat vector that drives the first linear layer's in_vec.
//  Two vector slots (ping-pong): one frame fills while the other is held stable for
//  the consumer. Sustains 1 feature/cycle with no bubbles while the consumer keeps up.
// PARAMETERS
//  IN_DIM    10      features per vector; 2..64
//  WIDTH     16      bits per feature, signed two's complement (Q8.8 at default)
// PORTS
//  clk        in   1             clock; all logic on posedge
//  rst        in   1             synchronous, active-high reset
//  s_valid    in   1             feature beat valid
//  s_ready    out  1             packer can accept a beat
//  s_data     in   WIDTH         signed feature
//  s_last     in   1             marks final feature of a frame
//  vec_valid  out  1             vec_data holds a complete frame
//  vec_ready  in   1             consumer takes vec_data this cycle
//  vec_data   out  IN_DIM*WIDTH  feature i at [i*WIDTH +: WIDTH]; index 0 = first beat
//  err_short  out  1             1-cycle pulse: s_last before IN_DIM beats
//  err_long   out  1             1-cycle pulse: beat IN_DIM-1 accepted without s_last
// BEHAVIOUR
//  - Beat accepted iff s_valid && s_ready. vec handshake iff vec_valid && vec_ready.
//  - Reset: both slots empty, wr_ptr=rd_ptr=0, cnt=0, state FILL; s_ready=1,
//    vec_valid=0, vec_data=0, err_short=0, err_long=0. Slot contents cleared.
//  - cnt (clog2(IN_DIM) bits) indexes the write slot; beat writes slot[wr_ptr][cnt].
//  - States: FILL (normal), DRAIN (discarding an over-long frame until s_last).
//  - FILL, accepted beat, cnt<IN_DIM-1, s_last=0: store, cnt++.
//  - FILL, accepted beat, cnt<IN_DIM-1, s_last=1: beat and partial frame discarded,
//    cnt=0, err_short pulses next cycle; slot stays empty.
//  - FILL, accepted beat, cnt==IN_DIM-1: store, mark slot full, wr_ptr toggles,
//    cnt=0. If s_last=0: err_long pulses, go DRAIN (frame still delivered).
//  - DRAIN: s_ready=1, accepted beats dropped; beat with s_last=1 returns to FILL.
//  - s_ready (FILL) = slot[wr_ptr] not full. Frame-complete beat on cycle N ->
//    vec_valid=1 on N+1 (1-cycle latency).
//  - vec_valid = slot[rd_ptr] full; vec_data = slot[rd_ptr] muxed from registers,
//    stable while vec_valid && !vec_ready. On handshake: slot emptied, rd_ptr toggles.
//  - Same-cycle frame completion into one slot and pop of the other: both take
//    effect; no lost beat, no bubble. Both full: s_ready=0 until a pop.
//  - Completing a frame while vec_ready=0: vec_valid held; data unchanged.
//  - No saturation/rescaling: s_data stored bit-exact.
//  - err_* are registered, mutually exclusive, never asserted during rst.
//  - rst mid-frame or with slots full: all in-flight data dropped, reset values
//    next cycle regardless of s_valid/vec_ready.
// STRUCTURE
//  - Shared pkg mlp_pkg: localparam WIDTH/FRAC defaults, typedef logic signed
//    [WIDTH-1:0] fx_t, typedef enum {FILL, DRAIN} packer_state_e.
//  - One sub-module: mlp_vec_slot (IN_DIM x WIDTH register bank with write-enable,
//    index, clear, full flag), instantiated twice. FSM/pointers in top.
// TESTING
//  - Reset, send 10 beats 0x0100..0x0A00, s_last on 10th, vec_ready=1 -> vec_valid
//    1 cycle after beat 10; vec_data[15:0]=0x0100, [159:144]=0x0A00; no err.
//  - 3 frames back-to-back, s_valid=1 continuously, vec_ready=0 -> s_ready drops
//    after frame 2 beat 10; frame 1 held stable; raise vec_ready -> frames 1,2,3 in order.
//  - s_last on beat 4 -> err_short pulse 1 cycle; next full 10-beat frame delivered
//    intact, no stale data from short frame.
//  - 13 beats, s_last on 13th -> err_long pulse after beat 10; frame 1 = beats 1..10;
//    beats 11..13 dropped; following frame correct.
//  - Negative values 0x8000/0xFFFF passed bit-exact; simultaneous fill/pop every
//    10 cycles with random vec_ready -> zero drops, order preserved vs scoreboard.
//  - Assert rst with slot 0 full and slot 1 at beat 5 -> next cycle vec_valid=0,
//    s_ready=1, vec_data=0; fresh frame afterward correct.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and defaults for the MLP datapath.
// Fixed-point feature type and input packer state encoding.
package mlp_pkg;
  localparam int WIDTH = 16;
  localparam int FRAC  = 8;

  typedef logic signed [WIDTH-1:0] fx_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } packer_state_e;
endpackage

// File: rtl/mlp_vec_slot.sv
// One frame buffer: IN_DIM x WIDTH registers plus a full flag.
// Written one feature at a time; read as a flat vector.
module mlp_vec_slot #(
  parameter int IN_DIM = 10,
  parameter int WIDTH  = 16,
  parameter int IW     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [IW-1:0]           idx_i,
  input  logic [WIDTH-1:0]        din_i,
  input  logic                    set_full_i,
  input  logic                    clr_full_i,
  output logic [IN_DIM*WIDTH-1:0] data_o,
  output logic                    full_o
);
  logic [WIDTH-1:0] mem_q [IN_DIM];
  logic             full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IN_DIM; i++) begin
        mem_q[i] <= '0;
      end
      full_q <= 1'b0;
    end else begin
      if (we_i) begin
        mem_q[idx_i] <= din_i;
      end
      if (set_full_i) begin
        full_q <= 1'b1;
      end else if (clr_full_i) begin
        full_q <= 1'b0;
      end
    end
  end

  always_comb begin
    data_o = '0;
    for (int i = 0; i < IN_DIM; i++) begin
      data_o[i*WIDTH +: WIDTH] = mem_q[i];
    end
  end

  assign full_o = full_q;
endmodule

// File: rtl/mlp_in_packer.sv
// Serial-to-parallel feature packer with ping-pong frame slots.
// Over-long frames are delivered truncated, the tail drained.
module mlp_in_packer #(
  parameter int IN_DIM = 10,
  parameter int WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH-1:0]        s_data,
  input  logic                    s_last,
  output logic                    vec_valid,
  input  logic                    vec_ready,
  output logic [IN_DIM*WIDTH-1:0] vec_data,
  output logic                    err_short,
  output logic                    err_long
);
  import mlp_pkg::*;

  localparam int CW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(IN_DIM - 1);

  packer_state_e   state_q;
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            err_short_q;
  logic            err_long_q;

  logic [1:0]              full;
  logic [1:0]              wsel;
  logic [1:0]              rsel;
  logic [IN_DIM*WIDTH-1:0] slot_data [2];
  logic accept;
  logic pop;
  logic at_last;
  logic fill_acc;
  logic wr_en;
  logic done;

  assign s_ready   = (state_q == DRAIN) | ~full[wr_ptr_q];
  assign accept    = s_valid & s_ready;
  assign vec_valid = full[rd_ptr_q];
  assign pop       = vec_valid & vec_ready;
  assign vec_data  = slot_data[rd_ptr_q];
  assign at_last   = (cnt_q == LAST);
  assign fill_acc  = accept & (state_q == FILL);
  // a short frame's closing beat is never stored
  assign wr_en     = fill_acc & (at_last | ~s_last);
  assign done      = fill_acc & at_last;
  assign wsel      = {wr_ptr_q, ~wr_ptr_q};
  assign rsel      = {rd_ptr_q, ~rd_ptr_q};

  for (genvar g = 0; g < 2; g++) begin : g_slot
    mlp_vec_slot #(
      .IN_DIM (IN_DIM),
      .WIDTH  (WIDTH),
      .IW     (CW)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .we_i       (wr_en & wsel[g]),
      .idx_i      (cnt_q),
      .din_i      (s_data),
      .set_full_i (done & wsel[g]),
      .clr_full_i (pop & rsel[g]),
      .data_o     (slot_data[g]),
      .full_o     (full[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case (state_q)
        FILL: begin
          if (accept) begin
            if (at_last) begin
              cnt_q    <= '0;
              wr_ptr_q <= ~wr_ptr_q;
              if (!s_last) begin
                err_long_q <= 1'b1;
                state_q    <= DRAIN;
              end
            end else if (s_last) begin
              cnt_q       <= '0;
              err_short_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (accept && s_last) begin
            state_q <= FILL;
          end
        end
      endcase
    end
  end

  assign err_short = err_short_q;
  assign err_long  = err_long_q;
endmodule
